// File: rtl/step_pulse_gen_pkg.sv
// step_pkg: shared state encoding and default timing/width constants for the step generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } step_state_t;

  localparam int STEP_DIV_W     = 15;
  localparam int STEP_CNT_W     = 15;
  localparam int STEP_PULSE_W   = 24;
  localparam int STEP_DIR_SETUP = 48;

endpackage

// File: rtl/step_pulse_gen_if.sv
// step_pulse_gen_if: segment command in, STEP/DIR and status out, between dispatcher and one axis.
// Latency: none (wires only).
// Backpressure: master must watch activeMode; loads while busy are dropped by the slave.
interface step_pulse_gen_if
  import step_pkg::*;
#(
  parameter int DIV_W = STEP_DIV_W,
  parameter int CNT_W = STEP_CNT_W
);
  logic             load;
  logic [DIV_W-1:0] divider;
  logic [CNT_W-1:0] stepsToGo;
  logic             dirInput;
  logic             step;
  logic             dir;
  logic             activeMode;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] stepsLeft;

  modport master (
    output load, divider, stepsToGo, dirInput,
    input  step, dir, activeMode, done, aborted, stepsLeft
  );

  modport slave (
    input  load, divider, stepsToGo, dirInput,
    output step, dir, activeMode, done, aborted, stepsLeft
  );
endinterface

// File: rtl/step_pulse_gen_term_sync.sv
// term_sync: 2-flop synchronizer for the raw active-low end-stop input.
// Latency: 2 cycles from a term change to termOut.
// Backpressure: none; resets to 1 (switch open) so reset never looks like a hit end-stop.
module term_sync (
  input  logic CLK,
  input  logic rst_n,
  input  logic termIn,
  output logic termOut
);
  logic meta;
  logic sync;

  // Two back-to-back flops to settle metastability on the asynchronous switch input.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= termIn;
      sync <= meta;
    end
  end

  assign termOut = sync;
endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: per-axis STEP/DIR generator for one segment; optional end-stop abort under STEP_TERM_STOP_EN.
// Latency: first STEP rise 1 cycle after an accepted load, 1+DIR_SETUP cycles when DIR changes.
// Backpressure: load accepted only in IDLE (including the done cycle); loads while busy are ignored.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int DIV_W     = STEP_DIV_W,
  parameter int CNT_W     = STEP_CNT_W,
  parameter int PULSE_W   = STEP_PULSE_W,
  parameter int DIR_SETUP = STEP_DIR_SETUP
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             term,
  step_pulse_gen_if.slave  bus
);
  // Phase counter is one bit wider than the divider so 2*PULSE_W never wraps.
  localparam logic [DIV_W:0]   MIN_P      = (DIV_W+1)'(2 * PULSE_W);
  localparam logic [DIV_W:0]   PULSE_LAST = (DIV_W+1)'(PULSE_W - 1);
  localparam logic [DIV_W:0]   SETUP_LAST = (DIV_W+1)'(DIR_SETUP - 1);
  localparam logic [DIV_W:0]   GAP_SUB    = (DIV_W+1)'(PULSE_W + 1);
  localparam logic [DIV_W:0]   PH_ONE     = (DIV_W+1)'(1);
  localparam logic [CNT_W-1:0] ONE_STEP   = CNT_W'(1);

  step_state_t      state;
  logic [DIV_W:0]   phase;
  logic [DIV_W:0]   period;
  logic [DIV_W:0]   divExt;
  logic [DIV_W:0]   pEff;
  logic [CNT_W-1:0] stepsLeftQ;
  logic             stepQ;
  logic             dirQ;
  logic             activeQ;
  logic             doneQ;
  logic             abortedQ;
  logic             homeBlocked;
  logic             abortNow;

`ifdef STEP_TERM_STOP_EN
  logic termSyncd;

  term_sync uTermSync (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .termIn  (term),
    .termOut (termSyncd)
  );

  assign homeBlocked = ~termSyncd;
`else
  // End-stop ignored in this build: never blocks, so aborted can never be set.
  logic unusedTerm;
  assign unusedTerm  = term;
  assign homeBlocked = 1'b0;
`endif

  // Period is clamped so the gap is never shorter than the STEP high time.
  assign divExt   = {1'b0, bus.divider};
  assign pEff     = (divExt > MIN_P) ? divExt : MIN_P;
  // Only motion toward home is stopped by the end-stop.
  assign abortNow = activeQ && !dirQ && homeBlocked;

  // Segment sequencer: IDLE -> [SETUP] -> (PULSE -> GAP)* -> IDLE, all outputs registered.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      period     <= '0;
      stepsLeftQ <= '0;
      stepQ      <= 1'b0;
      dirQ       <= 1'b0;
      activeQ    <= 1'b0;
      doneQ      <= 1'b0;
      abortedQ   <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            abortedQ <= 1'b0;
            if (!bus.dirInput && homeBlocked) begin
              doneQ    <= 1'b1;
              abortedQ <= 1'b1;
            end else if (bus.stepsToGo == '0 || bus.divider == '0) begin
              doneQ <= 1'b1;
            end else begin
              activeQ <= 1'b1;
              period  <= pEff;
              if (bus.dirInput != dirQ) begin
                dirQ       <= bus.dirInput;
                stepsLeftQ <= bus.stepsToGo;
                phase      <= SETUP_LAST;
                state      <= SETUP;
              end else begin
                stepsLeftQ <= bus.stepsToGo - ONE_STEP;
                stepQ      <= 1'b1;
                phase      <= PULSE_LAST;
                state      <= PULSE;
              end
            end
          end
        end

        SETUP: begin
          if (abortNow) begin
            state    <= IDLE;
            activeQ  <= 1'b0;
            doneQ    <= 1'b1;
            abortedQ <= 1'b1;
          end else if (phase == '0) begin
            stepsLeftQ <= stepsLeftQ - ONE_STEP;
            stepQ      <= 1'b1;
            phase      <= PULSE_LAST;
            state      <= PULSE;
          end else begin
            phase <= phase - PH_ONE;
          end
        end

        PULSE: begin
          // A started pulse always runs its full width, abort or not.
          if (phase == '0) begin
            stepQ <= 1'b0;
            if (abortNow) begin
              state    <= IDLE;
              activeQ  <= 1'b0;
              doneQ    <= 1'b1;
              abortedQ <= 1'b1;
            end else begin
              phase <= period - GAP_SUB;
              state <= GAP;
            end
          end else begin
            phase <= phase - PH_ONE;
          end
        end

        GAP: begin
          if (abortNow) begin
            state    <= IDLE;
            activeQ  <= 1'b0;
            doneQ    <= 1'b1;
            abortedQ <= 1'b1;
          end else if (phase == '0) begin
            if (stepsLeftQ != '0) begin
              stepsLeftQ <= stepsLeftQ - ONE_STEP;
              stepQ      <= 1'b1;
              phase      <= PULSE_LAST;
              state      <= PULSE;
            end else begin
              state   <= IDLE;
              activeQ <= 1'b0;
              doneQ   <= 1'b1;
            end
          end else begin
            phase <= phase - PH_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.step       = stepQ;
  assign bus.dir        = dirQ;
  assign bus.activeMode = activeQ;
  assign bus.done       = doneQ;
  assign bus.aborted    = abortedQ;
  assign bus.stepsLeft  = stepsLeftQ;
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed bench for step_pulse_gen with hand-computed STEP timing.
// Latency: checks sample on the falling edge, half a cycle after each active edge.
// Backpressure: exercises loads while busy and loads in the done cycle.
module tb_step_pulse_gen;
  localparam int DIV_W = 15;
  localparam int CNT_W = 15;
  localparam int PW    = 24;

  logic CLK;
  logic rst_n;
  logic term;
  int   checks;
  int   failures;

  step_pulse_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) sif ();

  step_pulse_gen #(
    .DIV_W     (DIV_W),
    .CNT_W     (CNT_W),
    .PULSE_W   (PW),
    .DIR_SETUP (48)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .term  (term),
    .bus   (sif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Called at a falling edge: that cycle is cycle 0 (load sampled at its end).
  task automatic run_seg(input string tag, input int div, input int n, input bit dIn,
                         input int firstRise, input int per, input bit expDir,
                         input int window, input int injAt);
    int stepErr, actErr, dirErr, doneCyc, doneCnt, endCyc;
    bit moving, expStep, expAct;
    stepErr = 0; actErr = 0; dirErr = 0; doneCyc = -1; doneCnt = 0;
    moving  = (n != 0) && (div != 0);
    endCyc  = moving ? firstRise + n * per : 1;
    sif.load      = 1'b1;
    sif.divider   = DIV_W'(div);
    sif.stepsToGo = CNT_W'(n);
    sif.dirInput  = dIn;
    for (int c = 1; c <= window; c++) begin
      @(negedge CLK);
      expStep = moving && (c >= firstRise) && (c < endCyc) && (((c - firstRise) % per) < PW);
      expAct  = moving && (c < endCyc);
      if (sif.step !== expStep) stepErr++;
      if (sif.activeMode !== expAct) actErr++;
      if (sif.dir !== expDir) dirErr++;
      if (sif.done === 1'b1) begin
        if (doneCnt == 0) doneCyc = c;
        doneCnt++;
      end
      if (moving && c == firstRise) begin
        checks++;
        if (sif.stepsLeft !== CNT_W'(n - 1)) begin
          failures++;
          $display("FAIL %s stepsLeftAtRise: got %0d, want %0d", tag, sif.stepsLeft, n - 1);
        end
      end
      sif.load = (c == injAt);
      if (c == injAt) begin
        sif.divider   = DIV_W'(300);
        sif.stepsToGo = CNT_W'(7);
        sif.dirInput  = ~dIn;
      end
    end
    checks++;
    if (stepErr != 0) begin
      failures++;
      $display("FAIL %s stepWave: %0d wrong cycles, want 0", tag, stepErr);
    end
    checks++;
    if (actErr != 0) begin
      failures++;
      $display("FAIL %s activeMode: %0d wrong cycles, want 0", tag, actErr);
    end
    checks++;
    if (dirErr != 0) begin
      failures++;
      $display("FAIL %s dir: %0d wrong cycles, want 0", tag, dirErr);
    end
    checks++;
    if (doneCyc != endCyc) begin
      failures++;
      $display("FAIL %s doneCycle: got %0d, want %0d", tag, doneCyc, endCyc);
    end
    checks++;
    if (doneCnt != 1) begin
      failures++;
      $display("FAIL %s donePulses: got %0d, want 1", tag, doneCnt);
    end
    checks++;
    if (sif.aborted !== 1'b0) begin
      failures++;
      $display("FAIL %s aborted: got %b, want 0", tag, sif.aborted);
    end
    if (moving) begin
      checks++;
      if (sif.stepsLeft !== '0) begin
        failures++;
        $display("FAIL %s stepsLeftEnd: got %0d, want 0", tag, sif.stepsLeft);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    term  = 1'b1;
    sif.load = 1'b0; sif.divider = '0; sif.stepsToGo = '0; sif.dirInput = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (sif.step !== 1'b0)       begin failures++; $display("FAIL reset step: got %b, want 0", sif.step); end
    checks++; if (sif.dir !== 1'b0)        begin failures++; $display("FAIL reset dir: got %b, want 0", sif.dir); end
    checks++; if (sif.activeMode !== 1'b0) begin failures++; $display("FAIL reset activeMode: got %b, want 0", sif.activeMode); end
    checks++; if (sif.done !== 1'b0)       begin failures++; $display("FAIL reset done: got %b, want 0", sif.done); end
    checks++; if (sif.aborted !== 1'b0)    begin failures++; $display("FAIL reset aborted: got %b, want 0", sif.aborted); end
    checks++; if (sif.stepsLeft !== '0)    begin failures++; $display("FAIL reset stepsLeft: got %0d, want 0", sif.stepsLeft); end
    rst_n = 1'b1;
    @(negedge CLK);
  endtask

  // Rises at 1, 101, 201; done at 301; dir stays 0.
  task automatic test_basic;
    run_seg("basic", 100, 3, 1'b0, 1, 100, 1'b0, 306, 0);
  endtask

  // DIR 0->1: dir at cycle 1, rise at 49, done at 249.
  task automatic test_dir_change;
    run_seg("dirChange", 200, 1, 1'b1, 49, 200, 1'b1, 255, 0);
  endtask

  // Period clamped to 48: rises 1, 49, done 97; busy load ignored; load in done cycle accepted.
  task automatic test_back_to_back;
    run_seg("clamp", 10, 2, 1'b1, 1, 48, 1'b1, 97, 20);
    run_seg("doneCycleLoad", 100, 1, 1'b1, 1, 100, 1'b1, 106, 0);
  endtask

  // Zero steps or zero divider: no motion, done at cycle 1, dir untouched.
  task automatic test_zero;
    run_seg("zeroSteps", 500, 0, 1'b0, 1, 1, 1'b1, 6, 0);
    run_seg("zeroDiv", 0, 5, 1'b0, 1, 1, 1'b1, 6, 0);
  endtask

  task automatic test_async_reset;
    sif.load = 1'b1; sif.divider = DIV_W'(100); sif.stepsToGo = CNT_W'(3); sif.dirInput = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      sif.load = 1'b0;
    end
    checks++;
    if (sif.step !== 1'b1) begin failures++; $display("FAIL preReset step: got %b, want 1", sif.step); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sif.step !== 1'b0)       begin failures++; $display("FAIL asyncReset step: got %b, want 0", sif.step); end
    checks++; if (sif.activeMode !== 1'b0) begin failures++; $display("FAIL asyncReset activeMode: got %b, want 0", sif.activeMode); end
    checks++; if (sif.dir !== 1'b0)        begin failures++; $display("FAIL asyncReset dir: got %b, want 0", sif.dir); end
    @(negedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    run_seg("postReset", 100, 3, 1'b0, 1, 100, 1'b0, 306, 0);
  endtask

`ifdef STEP_TERM_STOP_EN
  task automatic test_term_stop;
    int stepErr, actErr, doneCyc;
    bit expStep;
    stepErr = 0; actErr = 0; doneCyc = -1;
    sif.load = 1'b1; sif.divider = DIV_W'(100); sif.stepsToGo = CNT_W'(10); sif.dirInput = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      @(negedge CLK);
      sif.load = 1'b0;
      expStep = (c >= 1 && c <= 24) || (c >= 101 && c <= 124);
      if (sif.step !== expStep) stepErr++;
      if (sif.activeMode !== (c < 125)) actErr++;
      if (sif.done === 1'b1 && doneCyc < 0) doneCyc = c;
      if (c == 110) term = 1'b0;
    end
    checks++; if (stepErr != 0)          begin failures++; $display("FAIL termAbort stepWave: %0d wrong cycles, want 0", stepErr); end
    checks++; if (actErr != 0)           begin failures++; $display("FAIL termAbort activeMode: %0d wrong cycles, want 0", actErr); end
    checks++; if (doneCyc != 125)        begin failures++; $display("FAIL termAbort doneCycle: got %0d, want 125", doneCyc); end
    checks++; if (sif.aborted !== 1'b1)  begin failures++; $display("FAIL termAbort aborted: got %b, want 1", sif.aborted); end
    checks++; if (sif.stepsLeft !== CNT_W'(8)) begin failures++; $display("FAIL termAbort stepsLeft: got %0d, want 8", sif.stepsLeft); end

    stepErr = 0; doneCyc = -1;
    sif.load = 1'b1; sif.divider = DIV_W'(100); sif.stepsToGo = CNT_W'(3); sif.dirInput = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      sif.load = 1'b0;
      if (sif.step !== 1'b0 || sif.activeMode !== 1'b0) stepErr++;
      if (sif.done === 1'b1 && doneCyc < 0) doneCyc = c;
    end
    checks++; if (stepErr != 0)         begin failures++; $display("FAIL termBlocked motion: %0d wrong cycles, want 0", stepErr); end
    checks++; if (doneCyc != 1)         begin failures++; $display("FAIL termBlocked doneCycle: got %0d, want 1", doneCyc); end
    checks++; if (sif.aborted !== 1'b1) begin failures++; $display("FAIL termBlocked aborted: got %b, want 1", sif.aborted); end

    run_seg("termAwayFromHome", 100, 10, 1'b1, 49, 100, 1'b1, 1055, 0);
    term = 1'b1;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_dir_change();
    test_back_to_back();
    test_zero();
    test_async_reset();
`ifdef STEP_TERM_STOP_EN
    test_term_stop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
